// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the instruction-fetch front end of the
// 16-bit three-stage core.
package fetch_sequencer_pkg;

  localparam int WORD_LEN       = 16;
  localparam int INSTR_MEM_SIZE = 256;
  localparam int INSTR_BYTES    = 2;

  localparam logic [15:0] NOOP = 16'h0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus: the fetch unit drives a byte address and the
// combinational memory returns the big-endian 16-bit word at that address.
interface fetch_sequencer_if #(
  parameter int WORD_LEN = 16
);
  logic [WORD_LEN-1:0] imem_addr_o;
  logic [WORD_LEN-1:0] imem_instr_i;

  modport master (output imem_addr_o, input  imem_instr_i);
  modport slave  (input  imem_addr_o, output imem_instr_i);
endinterface

// File: rtl/fetch_sequencer_pc_target_calc.sv
// Branch/jump target: base + signed offset, forced even, folded into the
// instruction memory; flags an odd raw sum.
module pc_target_calc #(
  parameter int WORD_LEN  = 16,
  parameter int IMEM_SIZE = 256
) (
  input  logic        [WORD_LEN-1:0] base_i,
  input  logic signed [WORD_LEN-1:0] off_i,
  output logic        [WORD_LEN-1:0] target_o,
  output logic                       misalign_o
);

  localparam logic [WORD_LEN-1:0] ADDR_MASK = WORD_LEN'(IMEM_SIZE - 1);

  logic [WORD_LEN-1:0] sum;

  always_comb begin
    sum        = base_i + $unsigned(off_i);
    misalign_o = sum[0];
    target_o   = {sum[WORD_LEN-1:1], 1'b0} & ADDR_MASK;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills the IF/ID register and
// sequences boot, stall, redirect-with-squash and halt.
module fetch_sequencer #(
  parameter int                         WORD_LEN  = fetch_sequencer_pkg::WORD_LEN,
  parameter int                         IMEM_SIZE = fetch_sequencer_pkg::INSTR_MEM_SIZE,
  parameter logic [WORD_LEN-1:0]        RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       nReset,
  fetch_sequencer_if.master          imem,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic        [WORD_LEN-1:0] redirect_pc_i,
  input  logic signed [WORD_LEN-1:0] redirect_off_i,
  input  logic                       halt_i,
  output logic        [WORD_LEN-1:0] if_instr_o,
  output logic        [WORD_LEN-1:0] if_pc_o,
  output logic                       if_valid_o,
  output logic                       misalign_o,
  output logic                       halted_o,
  output logic        [WORD_LEN-1:0] fetch_cnt_o
);
  import fetch_sequencer_pkg::*;

  localparam logic [WORD_LEN-1:0] ADDR_MASK = WORD_LEN'(IMEM_SIZE - 1);
  localparam logic [WORD_LEN-1:0] PC_STEP   = WORD_LEN'(INSTR_BYTES);
  localparam logic [WORD_LEN-1:0] CNT_MAX   = '1;

  fetch_state_t        state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] if_instr_q, if_instr_d;
  logic [WORD_LEN-1:0] if_pc_q, if_pc_d;
  logic                if_valid_q, if_valid_d;
  logic                misalign_q, misalign_d;
  logic [WORD_LEN-1:0] fetch_cnt_q, fetch_cnt_d;

  logic [WORD_LEN-1:0] tgt_pc;
  logic                tgt_misalign;

  pc_target_calc #(
    .WORD_LEN  (WORD_LEN),
    .IMEM_SIZE (IMEM_SIZE)
  ) u_target (
    .base_i     (redirect_pc_i),
    .off_i      (redirect_off_i),
    .target_o   (tgt_pc),
    .misalign_o (tgt_misalign)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    misalign_d  = 1'b0;

    unique case (state_q)
      BOOT: begin
        // Settle cycle: nothing is latched, but a redirect still steers the PC.
        if (halt_i) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
          if (redirect_i) begin
            pc_d       = tgt_pc;
            misalign_d = tgt_misalign;
          end
        end
      end
      RUN: begin
        if (halt_i) begin
          state_d    = HALT;
          if_instr_d = WORD_LEN'(NOOP);
          if_valid_d = 1'b0;
        end else if (redirect_i) begin
          // The word fetched this cycle is wrong-path; squash it to a NOOP.
          pc_d       = tgt_pc;
          if_instr_d = WORD_LEN'(NOOP);
          if_valid_d = 1'b0;
          misalign_d = tgt_misalign;
        end else if (!stall_i) begin
          if_instr_d = imem.imem_instr_i;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = (pc_q + PC_STEP) & ADDR_MASK;
          if (fetch_cnt_q != CNT_MAX) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
          end
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem.imem_addr_o = pc_q;
  assign if_instr_o       = if_instr_q;
  assign if_pc_o          = if_pc_q;
  assign if_valid_o       = if_valid_q;
  assign misalign_o       = misalign_q;
  assign halted_o         = (state_q == HALT);
  assign fetch_cnt_o      = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed scenarios, counter
// saturation and a randomized run against a behavioural fetch model.
module tb_fetch_sequencer;

  localparam int IMEM = 256;

  logic        clk = 1'b0;
  logic        nReset;
  logic        stall_i, redirect_i, halt_i;
  logic [15:0] redirect_pc_i, redirect_off_i;
  logic [15:0] if_instr_o, if_pc_o, fetch_cnt_o;
  logic        if_valid_o, misalign_o, halted_o;

  logic [7:0] mem [IMEM];

  fetch_sequencer_if #(.WORD_LEN(16)) imem_bus ();

  assign imem_bus.imem_instr_i = {mem[imem_bus.imem_addr_o[7:0]],
                                  mem[8'(imem_bus.imem_addr_o[7:0] + 8'd1)]};

  fetch_sequencer #(.WORD_LEN(16), .IMEM_SIZE(IMEM), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .nReset         (nReset),
    .imem           (imem_bus),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .redirect_off_i (redirect_off_i),
    .halt_i         (halt_i),
    .if_instr_o     (if_instr_o),
    .if_pc_o        (if_pc_o),
    .if_valid_o     (if_valid_o),
    .misalign_o     (misalign_o),
    .halted_o       (halted_o),
    .fetch_cnt_o    (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int instr;
    int pc;
  } fetch_t;
  fetch_t exp_q[$];

  // Behavioural model: phase 0 = settling after reset, 1 = fetching, 2 = stopped.
  int m_phase, m_pc, m_cnt, m_instr, m_ipc;
  bit m_valid, m_mis;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int word_at(input int a);
    return (int'(mem[a % IMEM]) << 8) | int'(mem[(a + 1) % IMEM]);
  endfunction

  // One clock: drive inputs at the falling edge, advance the model, then
  // check the cycle-level outputs at the next falling edge.
  task automatic cycle(input bit rst_n, input bit halt, input bit redir,
                       input bit stall, input int rpc, input int roff);
    int sum, tgt;
    bit odd;
    nReset         = rst_n;
    halt_i         = halt;
    redirect_i     = redir;
    stall_i        = stall;
    redirect_pc_i  = 16'(rpc);
    redirect_off_i = 16'(roff);

    sum = (rpc + roff) % 65536;
    odd = sum[0];
    tgt = (sum - (sum % 2)) % IMEM;

    if (!rst_n) begin
      m_phase = 0; m_pc = 0; m_cnt = 0;
      m_valid = 0; m_mis = 0; m_instr = 0; m_ipc = 0;
    end else begin
      m_mis = 0;
      if (m_phase == 2) begin
      end else if (halt) begin
        m_phase = 2; m_valid = 0; m_instr = 0;
      end else if (redir) begin
        m_phase = 1; m_pc = tgt; m_mis = odd; m_valid = 0; m_instr = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (!stall) begin
        m_valid = 1;
        m_instr = word_at(m_pc);
        m_ipc   = m_pc;
        m_pc    = (m_pc + 2) % IMEM;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (m_valid) exp_q.push_back('{m_instr, m_ipc});

    @(posedge clk);
    @(negedge clk);
    chk("imem_addr", imem_bus.imem_addr_o, m_pc);
    chk("fetch_cnt", fetch_cnt_o, m_cnt);
    chk("if_valid", if_valid_o, int'(m_valid));
    chk("misalign", misalign_o, int'(m_mis));
    chk("halted", halted_o, int'(m_phase == 2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every presented IF/ID word is popped and matched.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (if_valid_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ifid_unexpected: got instr %0h pc %0h, expected no valid word",
                     if_instr_o, if_pc_o);
          end else begin
            fetch_t e;
            e = exp_q.pop_front();
            chk("ifid_instr", if_instr_o, e.instr);
            chk("ifid_pc", if_pc_o, e.pc);
          end
        end else begin
          chk("ifid_noop", if_instr_o, 0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < IMEM; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h01; mem[1] = 8'hF9;
    mem[2] = 8'h00; mem[3] = 8'h0B;
    mem[4] = 8'h42; mem[5] = 8'h88;
    nReset = 0; stall_i = 0; redirect_i = 0; halt_i = 0;
    redirect_pc_i = 0; redirect_off_i = 0;

    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    chk("reset_pc", imem_bus.imem_addr_o, 0);

    // Boot cycle, then three sequential fetches.
    idle(4);
    chk("boot_cnt3", fetch_cnt_o, 3);
    chk("boot_word3", if_instr_o, 16'h4288);
    chk("boot_pc3", if_pc_o, 4);

    // Stall at pc 6 for three cycles, then resume from 6.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 0);
    chk("stall_addr", imem_bus.imem_addr_o, 6);
    idle(1);
    chk("stall_resume_pc", if_pc_o, 6);

    // Redirect 16 + (-6) with stall asserted: target 10, one bubble.
    cycle(1, 0, 1, 1, 16, 16'hFFFA);
    chk("redir_addr", imem_bus.imem_addr_o, 10);
    chk("redir_bubble", if_valid_o, 0);
    idle(1);
    chk("redir_target_pc", if_pc_o, 10);

    // Odd target 4 + 3 -> 6 with a one-cycle misalign pulse.
    cycle(1, 0, 1, 0, 4, 3);
    chk("odd_addr", imem_bus.imem_addr_o, 6);
    chk("odd_misalign", misalign_o, 1);
    idle(1);
    chk("odd_misalign_drop", misalign_o, 0);

    // Wrap from IMEM_SIZE-2 back to 0.
    cycle(1, 0, 1, 0, 250, 4);
    idle(1);
    chk("wrap_pc", if_pc_o, 254);
    chk("wrap_addr", imem_bus.imem_addr_o, 0);
    idle(2);

    // Halt wins over a same-cycle redirect; only reset leaves HALT.
    cycle(1, 1, 1, 0, 100, 20);
    for (int i = 0; i < 5; i++) cycle(1, $urandom_range(0, 1), $urandom_range(0, 1),
                                     $urandom_range(0, 1), $urandom_range(0, 65535),
                                     $urandom_range(0, 65535));
    chk("halt_stays", halted_o, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("halt_reset_cnt", fetch_cnt_o, 0);
    chk("halt_reset_halted", halted_o, 0);
    idle(3);

    // Fetch counter saturation.
    cycle(0, 0, 0, 0, 0, 0);
    idle(65540);
    chk("cnt_saturated", fetch_cnt_o, 16'hFFFF);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit rst_n;
      r     = int'($urandom_range(0, 99));
      rst_n = !(r < 2 || (m_phase == 2 && $urandom_range(0, 3) == 0));
      cycle(rst_n, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 25, $urandom_range(0, 65535),
            $urandom_range(0, 65535));
    end
    idle(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 16-bit three-stage RISC core.
- Owns the program counter and drives the byte address into the combinational instruction memory, which returns one 16-bit instruction: the byte at the address is the high byte, the byte at address+1 is the low byte.
- Registers the fetched word into the IF/ID pipeline register and sequences stall, branch/jump redirect with wrong-path squash, and halt.
- Sits between the instruction memory and the decode/execute stages.

Parameters:
- WORD_LEN, 16, instruction and address width in bits.
- IMEM_SIZE, 256, instruction memory size in bytes; must be a power of two and at least 4.
- RESET_PC, 0, PC value loaded on reset; must be even.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nReset  input  1  synchronous, active-low reset.
- imem_addr_o  output  WORD_LEN  byte address to the instruction memory; always equals pc_q.
- imem_instr_i  input  WORD_LEN  instruction returned combinationally for imem_addr_o.
- stall_i  input  1  hold the PC and the IF/ID register this cycle.
- redirect_i  input  1  a taken branch or jump resolved in execute.
- redirect_pc_i  input  WORD_LEN  PC of the branching instruction.
- redirect_off_i  input  WORD_LEN  signed two's-complement byte offset.
- halt_i  input  1  stop fetching until reset.
- if_instr_o  output  WORD_LEN  IF/ID instruction; 16'h0000 (NOOP) when not valid.
- if_pc_o  output  WORD_LEN  PC of if_instr_o.
- if_valid_o  output  1  if_instr_o is a real instruction.
- misalign_o  output  1  one-cycle pulse when a redirect target was odd.
- halted_o  output  1  high while in the HALT state.
- fetch_cnt_o  output  WORD_LEN  count of valid fetches; saturates at 16'hFFFF.

Behaviour:
- Reset: while nReset is low at a clock edge, load pc_q=RESET_PC, if_instr_o=0, if_pc_o=0, if_valid_o=0, misalign_o=0, halted_o=0, fetch_cnt_o=0, state=BOOT. Reset has priority over every other input, including mid-stall, mid-redirect and HALT.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset release, giving the memory contents one settle cycle.
  - Nothing is latched; if_valid_o stays 0 and the PC holds.
  - Next state is RUN; a halt_i in this cycle goes to HALT instead.
  - A redirect_i in BOOT loads the target into the PC and the next state is still RUN.
- RUN: per-edge priority is halt_i, then redirect_i, then stall_i, then normal fetch.
  - Normal fetch: if_instr_o=imem_instr_i, if_pc_o=pc_q, if_valid_o=1, pc_q=(pc_q+2) mod IMEM_SIZE, fetch_cnt_o increments.
  - Fetch latency: an instruction appears on if_instr_o one cycle after its address is on imem_addr_o.
  - stall_i: pc_q, if_instr_o, if_pc_o, if_valid_o and fetch_cnt_o all hold.
  - redirect_i (stall_i ignored): target=(redirect_pc_i+redirect_off_i) mod 2^WORD_LEN, with bit 0 then forced to 0 and the result reduced mod IMEM_SIZE. pc_q=target. The IF/ID register is squashed: if_instr_o=0 and if_valid_o=0. misalign_o=1 for this cycle if the unmasked sum was odd.
  - The first instruction from the target appears two edges after the redirect edge, so exactly one bubble is inserted.
  - halt_i: go to HALT; pc_q holds; if_valid_o=0 and if_instr_o=0; any redirect in the same cycle is dropped.
- HALT: all registers hold and halted_o=1; the only exit is reset.
- Wrap-around:
  - The PC wraps from IMEM_SIZE-2 to 0.
  - Only the low log2(IMEM_SIZE) bits of the PC are nonzero; upper bits are always 0.
  - fetch_cnt_o saturates at 16'hFFFF and does not wrap.
- misalign_o is 0 in every cycle without a redirect.

Decomposition:
- Shared package (alongside the existing constants):
  - WORD_LEN, INSTR_MEM_SIZE and the INSTR_BYTES=2 constant.
  - The NOOP encoding 16'h0000.
  - An enumerated fetch_state_t {BOOT, RUN, HALT}.
- One natural sub-module, pc_target_calc: combinational adder, alignment mask, modulo reduction and misalign flag. It is reusable by the execute stage for link-address checks.
- The FSM, PC register, IF/ID register and counter stay in fetch_sequencer.

Test Plan:
- Reset, then release with the memory loaded as byte pairs 0x01/0xF9, 0x00/0x0B, 0x42/0x88 → edge 1 after release is BOOT (if_valid_o=0); edges 2–4 give if_instr_o=16'h01F9, 16'h000B, 16'h4288 with if_pc_o=0, 2, 4; fetch_cnt_o=3.
- stall_i high for 3 cycles at pc=6 → imem_addr_o stays 6, IF/ID and fetch_cnt_o frozen; after release the next fetch is from 6.
- redirect_i with redirect_pc_i=16, redirect_off_i=16'hFFFA (-6), together with stall_i=1 → pc_q=10, one squashed NOOP bubble, the instruction from address 10 valid two edges later, misalign_o=0.
- redirect with redirect_pc_i=4, redirect_off_i=3 → pc_q=6, misalign_o high for exactly one cycle.
- pc=IMEM_SIZE-2 with normal fetch → if_pc_o=254, next imem_addr_o=0; fetch_cnt_o preloaded near saturation holds at 16'hFFFF.
- halt_i with redirect_i in the same cycle → HALT, pc unchanged, halted_o=1, if_valid_o=0 indefinitely; nReset low for one edge → all outputs return to their reset values and BOOT restarts.
